// File: rtl/bus_grant_sched.sv
// 4-master round-robin bus grant scheduler: bounded hold window, lock, one-cycle dead handover.
// Per-master grant counters are built only when BUS_ARB_STATS_EN is defined.
module bus_grant_sched #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
`ifdef BUS_ARB_STATS_EN
    , parameter int CNT_W  = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           i_req,
    input  logic [3:0]           i_lock,
    output logic [3:0]           o_grant,
    output logic [1:0]           o_owner,
    output logic                 o_owner_vld,
    output logic                 o_preempt
`ifdef BUS_ARB_STATS_EN
    , input  logic               i_stats_clr
    , output logic [4*CNT_W-1:0] o_grant_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_HANDOVER} state_t;

    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state, w_state;
    logic [1:0]        r_owner, w_owner;
    logic [1:0]        r_last, w_last;
    logic [1:0]        r_nxt, w_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold;
    logic [3:0]        r_grant, w_grant;
    logic              r_preempt, w_preempt;
    logic              w_enter;
    logic [3:0]        w_others;

    // Search order starts just after the last owner and ends on it.
    function automatic logic [1:0] f_rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        f_rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) f_rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        f_onehot = 4'b0001 << idx;
    endfunction

    assign w_others = i_req & ~f_onehot(r_owner);

    always_comb begin
        w_state   = r_state;
        w_owner   = r_owner;
        w_last    = r_last;
        w_nxt     = r_nxt;
        w_hold    = r_hold;
        w_preempt = 1'b0;
        w_enter   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_state = S_OWN;
                    w_owner = f_rr_pick(i_req, r_last);
                    w_last  = w_owner;
                    w_hold  = '0;
                    w_enter = 1'b1;
                end
            end
            S_OWN: begin
                // Release wins over preemption when both hold in the same cycle.
                if (!i_req[r_owner]) begin
                    if (|w_others) begin
                        w_state = S_HANDOVER;
                        w_nxt   = f_rr_pick(i_req, r_last);
                    end else begin
                        w_state = S_IDLE;
                    end
                end else if (r_hold == HOLD_SAT && |w_others && !i_lock[r_owner]) begin
                    w_state   = S_HANDOVER;
                    w_nxt     = f_rr_pick(w_others, r_last);
                    w_preempt = 1'b1;
                end else if (r_hold != HOLD_SAT) begin
                    w_hold = r_hold + HOLD_W'(1);
                end
            end
            S_HANDOVER: begin
                if (i_req[r_nxt]) begin
                    w_state = S_OWN;
                    w_owner = r_nxt;
                    w_last  = r_nxt;
                    w_hold  = '0;
                    w_enter = 1'b1;
                end else begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_grant = (w_state == S_OWN) ? f_onehot(w_owner) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_nxt     <= 2'd0;
            r_hold    <= '0;
            r_grant   <= 4'b0000;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_last    <= w_last;
            r_nxt     <= w_nxt;
            r_hold    <= w_hold;
            r_grant   <= w_grant;
            r_preempt <= w_preempt;
        end
    end

    assign o_grant     = r_grant;
    assign o_owner     = r_owner;
    assign o_owner_vld = |r_grant;
    assign o_preempt   = r_preempt;

`ifdef BUS_ARB_STATS_EN
    logic [3:0][CNT_W-1:0] r_cnt;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (reset || i_stats_clr)
                r_cnt[gi] <= '0;
            else if (w_enter && w_owner == 2'(gi) && r_cnt[gi] != '1)
                r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end
    end

    assign o_grant_cnt = r_cnt;
`endif

endmodule
